// File: rtl/hack_exec_unit.sv
// ----------------------------------------------------------------------------
// hack_exec_unit: sequential execute stage for 16-bit Hack instructions.
//
// Accepts instructions over a valid/ready handshake and holds the A and D
// registers. It fetches the M operand from data memory when an instruction
// needs it, drives an internal Hack ALU, commits the result to A, D and/or
// memory, and reports the jump decision plus target to the fetch stage.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_instr_valid/_ready    instruction handshake, i_instr is the word
//   o_mem_addr              data memory address (old A while writing)
//   o_mem_rd, i_mem_rdata,  read request held until i_mem_rvalid
//   i_mem_rvalid
//   o_mem_wr, o_mem_wdata,  write request held until i_mem_wack
//   i_mem_wack
//   o_done                  one-cycle retire pulse
//   o_jump, o_jump_target   jump decision / pre-instruction A, valid with o_done
//   o_a, o_d                current A and D registers
//
// The file also holds the combinational Hack ALU (module alu) that the
// execute stage instantiates.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// alu: combinational Hack ALU.
// Ports: x_i, y_i operands; zx_i/nx_i/zy_i/ny_i/f_i/no_i control bits;
//        out_o result, zr_o result is zero, ng_o result is negative.
// ----------------------------------------------------------------------------
module alu #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] x_i,
  input  logic [BUS_WIDTH-1:0] y_i,
  input  logic                 zx_i,
  input  logic                 nx_i,
  input  logic                 zy_i,
  input  logic                 ny_i,
  input  logic                 f_i,
  input  logic                 no_i,
  output logic [BUS_WIDTH-1:0] out_o,
  output logic                 zr_o,
  output logic                 ng_o
);

  logic [BUS_WIDTH-1:0] x_s;
  logic [BUS_WIDTH-1:0] y_s;
  logic [BUS_WIDTH-1:0] f_s;

  // Operand conditioning, function select and optional output inversion.
  always_comb begin
    x_s = x_i;
    y_s = y_i;
    f_s = {BUS_WIDTH{1'b0}};
    if (zx_i) begin
      x_s = {BUS_WIDTH{1'b0}};
    end else begin
      x_s = x_i;
    end
    if (nx_i) begin
      x_s = ~x_s;
    end else begin
      x_s = x_s;
    end
    if (zy_i) begin
      y_s = {BUS_WIDTH{1'b0}};
    end else begin
      y_s = y_i;
    end
    if (ny_i) begin
      y_s = ~y_s;
    end else begin
      y_s = y_s;
    end
    if (f_i) begin
      f_s = x_s + y_s;   // wraps modulo 2^BUS_WIDTH
    end else begin
      f_s = x_s & y_s;
    end
    if (no_i) begin
      f_s = ~f_s;
    end else begin
      f_s = f_s;
    end
  end

  assign out_o = f_s;
  assign zr_o  = (f_s == {BUS_WIDTH{1'b0}});
  assign ng_o  = f_s[BUS_WIDTH-1];

endmodule

module hack_exec_unit #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_instr_valid,
  output logic                 o_instr_ready,
  input  logic [15:0]          i_instr,
  output logic [BUS_WIDTH-1:0] o_mem_addr,
  output logic                 o_mem_rd,
  input  logic [BUS_WIDTH-1:0] i_mem_rdata,
  input  logic                 i_mem_rvalid,
  output logic                 o_mem_wr,
  output logic [BUS_WIDTH-1:0] o_mem_wdata,
  input  logic                 i_mem_wack,
  output logic                 o_done,
  output logic                 o_jump,
  output logic [BUS_WIDTH-1:0] o_jump_target,
  output logic [BUS_WIDTH-1:0] o_a,
  output logic [BUS_WIDTH-1:0] o_d
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]           state_q,  state_d;
  logic [BUS_WIDTH-1:0] a_q,      a_d;
  logic [BUS_WIDTH-1:0] d_q,      d_d;
  logic [BUS_WIDTH-1:0] m_q,      m_d;
  // Only bits [12:0] of a C-instruction matter once it has been decoded.
  logic [12:0]          ir_q,     ir_d;
  logic [BUS_WIDTH-1:0] wdata_q,  wdata_d;
  logic [BUS_WIDTH-1:0] waddr_q,  waddr_d;
  logic                 done_q,   done_d;
  logic                 jump_q,   jump_d;
  logic [BUS_WIDTH-1:0] target_q, target_d;

  logic [BUS_WIDTH-1:0] alu_y_s;
  logic [BUS_WIDTH-1:0] alu_r_s;
  logic                 alu_zr_s;
  logic                 alu_ng_s;
  logic                 jump_s;

  // Held instruction field aliases.
  logic sel_m_s, dst_a_s, dst_d_s, dst_m_s;
  assign sel_m_s = ir_q[12];
  assign dst_a_s = ir_q[5];
  assign dst_d_s = ir_q[4];
  assign dst_m_s = ir_q[3];

  assign alu_y_s = sel_m_s ? m_q : a_q;

  alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
    .x_i  (d_q),
    .y_i  (alu_y_s),
    .zx_i (ir_q[11]),
    .nx_i (ir_q[10]),
    .zy_i (ir_q[9]),
    .ny_i (ir_q[8]),
    .f_i  (ir_q[7]),
    .no_i (ir_q[6]),
    .out_o(alu_r_s),
    .zr_o (alu_zr_s),
    .ng_o (alu_ng_s)
  );

  // "Greater than zero" is neither negative nor zero.
  assign jump_s = (ir_q[2] & alu_ng_s)
                | (ir_q[1] & alu_zr_s)
                | (ir_q[0] & ~alu_ng_s & ~alu_zr_s);

  // Next-state and datapath update for the IDLE/READ/EXEC/WRITE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    d_d      = d_q;
    m_d      = m_q;
    ir_d     = ir_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    done_d   = 1'b0;
    jump_d   = jump_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (i_instr_valid) begin
          if (!i_instr[15]) begin
            a_d      = {{(BUS_WIDTH-15){1'b0}}, i_instr[14:0]};
            done_d   = 1'b1;
            jump_d   = 1'b0;
            target_d = a_q;
          end else begin
            ir_d    = i_instr[12:0];
            state_d = i_instr[12] ? S_READ : S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (i_mem_rvalid) begin
          m_d     = i_mem_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_READ;
        end
      end
      S_EXEC: begin
        if (dst_a_s) begin
          a_d = alu_r_s;
        end else begin
          a_d = a_q;
        end
        if (dst_d_s) begin
          d_d = alu_r_s;
        end else begin
          d_d = d_q;
        end
        // Target and write address are the A value before this commit.
        jump_d   = jump_s;
        target_d = a_q;
        waddr_d  = a_q;
        if (dst_m_s) begin
          wdata_d = alu_r_s;
          state_d = S_WRITE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (i_mem_wack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any op.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= {BUS_WIDTH{1'b0}};
      d_q      <= {BUS_WIDTH{1'b0}};
      m_q      <= {BUS_WIDTH{1'b0}};
      ir_q     <= 13'h0000;
      wdata_q  <= {BUS_WIDTH{1'b0}};
      waddr_q  <= {BUS_WIDTH{1'b0}};
      done_q   <= 1'b0;
      jump_q   <= 1'b0;
      target_q <= {BUS_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      m_q      <= m_d;
      ir_q     <= ir_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      done_q   <= done_d;
      jump_q   <= jump_d;
      target_q <= target_d;
    end
  end

  assign o_instr_ready = (state_q == S_IDLE) & ~i_rst;
  assign o_mem_rd      = (state_q == S_READ);
  assign o_mem_wr      = (state_q == S_WRITE);
  assign o_mem_addr    = (state_q == S_WRITE) ? waddr_q : a_q;
  assign o_mem_wdata   = wdata_q;
  assign o_done        = done_q;
  assign o_jump        = jump_q;
  assign o_jump_target = target_q;
  assign o_a           = a_q;
  assign o_d           = d_q;

endmodule

// File: tb/tb_hack_exec_unit.sv
// ----------------------------------------------------------------------------
// Bench for hack_exec_unit: retire expectations go into a scoreboard queue
// when an instruction is issued and are checked whenever o_done pulses; each
// scenario task also checks its own handshake and memory timing inline.
// ----------------------------------------------------------------------------
module tb_hack_exec_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [15:0] i_instr;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic [15:0] i_mem_rdata;
  logic        i_mem_rvalid;
  logic        o_mem_wr;
  logic [15:0] o_mem_wdata;
  logic        i_mem_wack;
  logic        o_done;
  logic        o_jump;
  logic [15:0] o_jump_target;
  logic [15:0] o_a;
  logic [15:0] o_d;

  typedef struct packed {
    logic        jump;
    logic [15:0] target;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  hack_exec_unit #(.BUS_WIDTH(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready),
    .i_instr      (i_instr),
    .o_mem_addr   (o_mem_addr),
    .o_mem_rd     (o_mem_rd),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_rvalid (i_mem_rvalid),
    .o_mem_wr     (o_mem_wr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_wack   (i_mem_wack),
    .o_done       (o_done),
    .o_jump       (o_jump),
    .o_jump_target(o_jump_target),
    .o_a          (o_a),
    .o_d          (o_d)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard: every retire pulse must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (o_done === 1'b1) begin
      exp_t e;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected: got o_done=1 with a=%h d=%h, required no retire", o_a, o_d);
      end else begin
        e = sb_q.pop_front();
        if ({o_jump, o_jump_target, o_a, o_d} !== e) begin
          bad++;
          $display("FAIL retire_fields: got jump=%0b tgt=%h a=%h d=%h, required jump=%0b tgt=%h a=%h d=%h",
                   o_jump, o_jump_target, o_a, o_d, e.jump, e.target, e.a, e.d);
        end
      end
    end
  end

  task automatic push_exp(input logic j, input logic [15:0] t, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.jump = j; e.target = t; e.a = a; e.d = d;
    sb_q.push_back(e);
  endtask

  // Offer one instruction for a single cycle; returns at the negedge after accept.
  task automatic send(input logic [15:0] ins);
    i_instr_valid = 1'b1;
    i_instr       = ins;
    @(negedge i_clk);
    i_instr_valid = 1'b0;
    i_instr       = 16'h0000;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_instr_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_low: got %0b required 0", o_instr_ready);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_instr_ready, o_a, o_d, o_done, o_mem_rd, o_mem_wr, o_jump} !== {1'b1, 16'h0, 16'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state: got ready=%0b a=%h d=%h done=%0b rd=%0b wr=%0b jump=%0b required ready=1 rest 0",
               o_instr_ready, o_a, o_d, o_done, o_mem_rd, o_mem_wr, o_jump);
    end
  endtask

  task automatic test_a_instr();
    push_exp(1'b0, 16'h0000, 16'h0005, 16'h0000);
    send(16'h0005);
    total++;
    if ({o_done, o_a, o_d, o_instr_ready} !== {1'b1, 16'h0005, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL a_instr: got done=%0b a=%h d=%h ready=%0b required done=1 a=0005 d=0000 ready=1",
               o_done, o_a, o_d, o_instr_ready);
    end
  endtask

  task automatic test_c_seq();
    logic [15:0] instrs [2];
    logic [15:0] dvals  [2];
    instrs[0] = 16'hEC10; dvals[0] = 16'h0005;   // D=A
    instrs[1] = 16'hE7D0; dvals[1] = 16'h0006;   // D=D+1
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 16'h0005, 16'h0005, dvals[i]);
      send(instrs[i]);
      total++;
      if ({o_done, o_mem_rd, o_mem_wr, o_instr_ready} !== 4'b0000) begin
        bad++;
        $display("FAIL c_exec_cycle%0d: got done=%0b rd=%0b wr=%0b ready=%0b required all 0",
                 i, o_done, o_mem_rd, o_mem_wr, o_instr_ready);
      end
      @(negedge i_clk);
      total++;
      if ({o_done, o_d, o_mem_rd, o_mem_wr} !== {1'b1, dvals[i], 2'b00}) begin
        bad++;
        $display("FAIL c_retire%0d: got done=%0b d=%h rd=%0b wr=%0b required done=1 d=%h no mem",
                 i, o_done, o_d, o_mem_rd, o_mem_wr, dvals[i]);
      end
    end
  endtask

  task automatic test_write();
    push_exp(1'b0, 16'h0005, 16'h0010, 16'h0006);
    send(16'h0010);
    push_exp(1'b0, 16'h0010, 16'h0010, 16'h0006);
    send(16'hE308);                               // M=D
    @(negedge i_clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({o_mem_wr, o_mem_addr, o_mem_wdata, o_done} !== {1'b1, 16'h0010, 16'h0006, 1'b0}) begin
        bad++;
        $display("FAIL write_hold%0d: got wr=%0b addr=%h wdata=%h done=%0b required wr=1 addr=0010 wdata=0006 done=0",
                 k, o_mem_wr, o_mem_addr, o_mem_wdata, o_done);
      end
      i_mem_wack = (k == 3) ? 1'b1 : 1'b0;
      @(negedge i_clk);
    end
    i_mem_wack = 1'b0;
    total++;
    if ({o_done, o_mem_wr} !== 2'b10) begin
      bad++; $display("FAIL write_retire: got done=%0b wr=%0b required done=1 wr=0", o_done, o_mem_wr);
    end
  endtask

  task automatic test_read();
    push_exp(1'b0, 16'h0010, 16'h0020, 16'h0006);
    send(16'h0020);
    push_exp(1'b0, 16'h0020, 16'h0020, 16'h1234);
    send(16'hFC10);                               // D=M
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_mem_rd, o_mem_addr, o_mem_wr} !== {1'b1, 16'h0020, 1'b0}) begin
        bad++;
        $display("FAIL read_hold%0d: got rd=%0b addr=%h wr=%0b required rd=1 addr=0020 wr=0",
                 k, o_mem_rd, o_mem_addr, o_mem_wr);
      end
      if (k == 2) begin
        i_mem_rvalid = 1'b1; i_mem_rdata = 16'h1234;
      end else begin
        i_mem_rvalid = 1'b0; i_mem_rdata = 16'hDEAD;
      end
      @(negedge i_clk);
    end
    i_mem_rvalid = 1'b0; i_mem_rdata = 16'h0000;
    total++;
    if ({o_done, o_mem_rd} !== 2'b00) begin
      bad++; $display("FAIL read_exec: got done=%0b rd=%0b required 0 0", o_done, o_mem_rd);
    end
    @(negedge i_clk);
    total++;
    if ({o_done, o_d} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL read_retire: got done=%0b d=%h required done=1 d=1234", o_done, o_d);
    end
  endtask

  task automatic test_jump();
    logic [15:0] ins  [10];
    logic        exj  [10];
    logic [15:0] ext  [10];
    logic [15:0] exa  [10];
    logic [15:0] exd  [10];
    ins[0]=16'hEA87; exj[0]=1'b1; ext[0]=16'h0020; exa[0]=16'h0020; exd[0]=16'h1234; // 0;JMP
    ins[1]=16'h0006; exj[1]=1'b0; ext[1]=16'h0020; exa[1]=16'h0006; exd[1]=16'h1234;
    ins[2]=16'hEC10; exj[2]=1'b0; ext[2]=16'h0006; exa[2]=16'h0006; exd[2]=16'h0006; // D=A
    ins[3]=16'hE302; exj[3]=1'b0; ext[3]=16'h0006; exa[3]=16'h0006; exd[3]=16'h0006; // D;JEQ
    ins[4]=16'hEA90; exj[4]=1'b0; ext[4]=16'h0006; exa[4]=16'h0006; exd[4]=16'h0000; // D=0
    ins[5]=16'hE302; exj[5]=1'b1; ext[5]=16'h0006; exa[5]=16'h0006; exd[5]=16'h0000; // D;JEQ
    ins[6]=16'hEE90; exj[6]=1'b0; ext[6]=16'h0006; exa[6]=16'h0006; exd[6]=16'hFFFF; // D=-1
    ins[7]=16'hE304; exj[7]=1'b1; ext[7]=16'h0006; exa[7]=16'h0006; exd[7]=16'hFFFF; // D;JLT
    ins[8]=16'hE301; exj[8]=1'b0; ext[8]=16'h0006; exa[8]=16'h0006; exd[8]=16'hFFFF; // D;JGT
    ins[9]=16'hEDE7; exj[9]=1'b1; ext[9]=16'h0006; exa[9]=16'h0007; exd[9]=16'hFFFF; // A=A+1;JMP
    for (int i = 0; i < 10; i++) begin
      push_exp(exj[i], ext[i], exa[i], exd[i]);
      send(ins[i]);
      if (ins[i][15]) begin
        @(negedge i_clk);
      end else begin
        i_instr = 16'h0000;
      end
      total++;
      if ({o_done, o_jump, o_jump_target} !== {1'b1, exj[i], ext[i]}) begin
        bad++;
        $display("FAIL jump%0d: got done=%0b jump=%0b tgt=%h required done=1 jump=%0b tgt=%h",
                 i, o_done, o_jump, o_jump_target, exj[i], ext[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 16'h0007, 16'h0001, 16'hFFFF);
    push_exp(1'b0, 16'h0001, 16'h0002, 16'hFFFF);
    i_instr_valid = 1'b1; i_instr = 16'h0001;
    @(negedge i_clk);
    i_instr = 16'h0002;
    total++;
    if ({o_done, o_a, o_instr_ready} !== {1'b1, 16'h0001, 1'b1}) begin
      bad++; $display("FAIL b2b_first: got done=%0b a=%h ready=%0b required 1 0001 1", o_done, o_a, o_instr_ready);
    end
    @(negedge i_clk);
    i_instr_valid = 1'b0; i_instr = 16'h0000;
    total++;
    if ({o_done, o_a} !== {1'b1, 16'h0002}) begin
      bad++; $display("FAIL b2b_second: got done=%0b a=%h required 1 0002", o_done, o_a);
    end
  endtask

  task automatic test_reset_abort();
    push_exp(1'b0, 16'h0002, 16'h0010, 16'hFFFF);
    send(16'h0010);
    send(16'hE308);                               // M=D, aborted in WRITE
    @(negedge i_clk);
    total++;
    if ({o_mem_wr, o_mem_addr, o_mem_wdata} !== {1'b1, 16'h0010, 16'hFFFF}) begin
      bad++; $display("FAIL abort_write_req: got wr=%0b addr=%h wdata=%h required 1 0010 ffff",
                      o_mem_wr, o_mem_addr, o_mem_wdata);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    total++;
    if ({o_mem_wr, o_done, o_a, o_d, o_instr_ready} !== {2'b00, 16'h0, 16'h0, 1'b0}) begin
      bad++; $display("FAIL abort_state: got wr=%0b done=%0b a=%h d=%h ready=%0b required all 0",
                      o_mem_wr, o_done, o_a, o_d, o_instr_ready);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    i_mem_wack = 1'b1;                            // stray ack after abort
    @(negedge i_clk);
    i_mem_wack = 1'b0;
    @(negedge i_clk);
    total++;
    if ({o_mem_wr, o_mem_rd, o_done, o_instr_ready, o_a, o_d} !== {3'b000, 1'b1, 16'h0, 16'h0}) begin
      bad++; $display("FAIL abort_stray_wack: got wr=%0b rd=%0b done=%0b ready=%0b a=%h d=%h required idle zeros",
                      o_mem_wr, o_mem_rd, o_done, o_instr_ready, o_a, o_d);
    end
    push_exp(1'b0, 16'h0000, 16'h0003, 16'h0000);
    send(16'h0003);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1; i_instr_valid = 1'b0; i_instr = 16'h0000;
    i_mem_rdata = 16'h0000; i_mem_rvalid = 1'b0; i_mem_wack = 1'b0;
    test_reset();
    test_a_instr();
    test_c_seq();
    test_write();
    test_read();
    test_jump();
    test_back_to_back();
    test_reset_abort();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending retires required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
